// File: rtl/stage_monitor.sv
// stage_monitor: watches a stage code and error flags coming from a device
// under test and reports whether the run passes, fails or times out.
// The stage and error inputs are sampled once per SAMPLE_DIV clock cycles.
// Optional feature: define STAGE_ORDER_CHECK_EN to reject out-of-order stage
// changes (fail code 4). Without it, any stage change is accepted.
//
// state   | meaning
// ST_RUN  | monitoring; evaluates inputs on every sample strobe
// ST_PASS | PASS_CODE seen; absorbing until reset
// ST_FAIL | error, timeout or order violation; absorbing until reset
module stage_monitor #(
  parameter int STAGE_W    = 8,
  parameter int ERR_W      = 1,
  parameter int SAMPLE_DIV = 100,
  parameter int GLOBAL_TO  = 24000,
  parameter int STAGE_TO   = 0,
  parameter int PASS_CODE  = 254
) (
  input  logic               clock,
  input  logic               RSTB,
  input  logic [STAGE_W-1:0] stage,
  input  logic [ERR_W-1:0]   err,
  output logic [STAGE_W-1:0] cur_stage,
  output logic               stage_evt,
  output logic               done,
  output logic               pass,
  output logic [2:0]         fail_code,
  output logic [ERR_W-1:0]   err_chan
);

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STAGE_W-1:0] r_stage_s1, r_stage_s2;
  logic [ERR_W-1:0]   r_err_s1, r_err_s2;
  logic [15:0]        r_pre;
  logic [CNT_W-1:0]   r_gcnt, r_scnt;
  logic [STAGE_W-1:0] r_cur_stage;
  logic               r_stage_evt, r_done, r_pass;
  logic [2:0]         r_fail_code;
  logic [ERR_W-1:0]   r_err_chan;

  logic               w_strobe, w_chg, w_pass_hit, w_gto, w_sto, w_order_bad;
  logic               w_load, w_count;
  logic [2:0]         w_code_nxt;

  // Two-flop synchronisers for the asynchronous DUT pins
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      r_stage_s1 <= '0;
      r_stage_s2 <= '0;
      r_err_s1   <= '0;
      r_err_s2   <= '0;
    end else begin
      r_stage_s1 <= stage;
      r_stage_s2 <= r_stage_s1;
      r_err_s1   <= err;
      r_err_s2   <= r_err_s1;
    end
  end

  // Sample prescaler: strobe on terminal count, then wrap
  assign w_strobe = (r_pre == 16'(SAMPLE_DIV - 1));

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB)         r_pre <= '0;
    else if (w_strobe) r_pre <= '0;
    else               r_pre <= r_pre + 16'd1;
  end

  assign w_chg      = (r_stage_s2 != r_cur_stage);
  assign w_pass_hit = (r_stage_s2 == STAGE_W'(PASS_CODE));
  assign w_gto      = (r_gcnt == CNT_W'(GLOBAL_TO - 1));
  // A stage change on the same strobe wins over the stage timeout
  assign w_sto      = (STAGE_TO != 0) && (r_scnt == CNT_W'(STAGE_TO - 1)) && !w_chg;

`ifdef STAGE_ORDER_CHECK_EN
  logic [STAGE_W-1:0] w_cur_inc;
  assign w_cur_inc   = r_cur_stage + STAGE_W'(1);
  assign w_order_bad = w_chg && (r_stage_s2 != w_cur_inc) && !w_pass_hit &&
                       (r_stage_s2 != {STAGE_W{1'b1}});
`else
  assign w_order_bad = 1'b0;
`endif

  // Next-state decision in priority order on each strobe while running
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = 3'd0;
    w_load      = 1'b0;
    w_count     = 1'b0;
    if (r_state == ST_RUN && w_strobe) begin
      if (|r_err_s2) begin
        w_state_nxt = ST_FAIL;
        w_code_nxt  = 3'd1;
      end else if (w_order_bad) begin
        w_state_nxt = ST_FAIL;
        w_code_nxt  = 3'd4;
      end else if (w_pass_hit) begin
        w_state_nxt = ST_PASS;
        w_load      = w_chg;
      end else if (w_gto) begin
        w_state_nxt = ST_FAIL;
        w_code_nxt  = 3'd2;
      end else if (w_sto) begin
        w_state_nxt = ST_FAIL;
        w_code_nxt  = 3'd3;
      end else begin
        w_load  = w_chg;
        w_count = 1'b1;
      end
    end
  end

  // State register and sticky result flags
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      r_state     <= ST_RUN;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= 3'd0;
      r_err_chan  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN && w_state_nxt == ST_PASS) begin
        r_done <= 1'b1;
        r_pass <= 1'b1;
      end
      if (r_state == ST_RUN && w_state_nxt == ST_FAIL) begin
        r_done      <= 1'b1;
        r_fail_code <= w_code_nxt;
        r_err_chan  <= r_err_s2;
      end
    end
  end

  // Accepted stage code and its one-cycle event pulse
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      r_cur_stage <= '0;
      r_stage_evt <= 1'b0;
    end else begin
      r_stage_evt <= w_load;
      if (w_load) r_cur_stage <= r_stage_s2;
    end
  end

  // Saturating global and per-stage sample counters
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      r_gcnt <= '0;
      r_scnt <= '0;
    end else begin
      if (w_count && r_gcnt != {CNT_W{1'b1}}) r_gcnt <= r_gcnt + CNT_W'(1);
      if (w_load)                                      r_scnt <= '0;
      else if (w_count && r_scnt != {CNT_W{1'b1}})     r_scnt <= r_scnt + CNT_W'(1);
    end
  end

  assign cur_stage = r_cur_stage;
  assign stage_evt = r_stage_evt;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_code = r_fail_code;
  assign err_chan  = r_err_chan;

endmodule

// File: doc/stage_monitor.md
STAGE_MONITOR -- requirements
Module: stage_monitor

Interface
REQ-001 SHALL have parameter STAGE_W, default 8: width of the stage code bus.
REQ-002 SHALL have parameter ERR_W, default 1: number of independent error-flag inputs.
REQ-003 SHALL have parameter SAMPLE_DIV, default 100: clock cycles per sample strobe, legal range 1..65535.
REQ-004 SHALL have parameter GLOBAL_TO, default 24000: samples until global timeout.
REQ-005 SHALL have parameter STAGE_TO, default 0: samples allowed per stage; 0 disables the per-stage timeout.
REQ-006 SHALL have parameter PASS_CODE, default 254: stage code that signals pass.
REQ-007 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-008 SHALL have port RSTB, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port stage, input, STAGE_W bits: asynchronous stage code from the DUT pins.
REQ-010 SHALL have port err, input, ERR_W bits: asynchronous error flags, active-high.
REQ-011 SHALL have port cur_stage, output, STAGE_W bits: last accepted stage code.
REQ-012 SHALL have port stage_evt, output, 1 bit: one-cycle pulse when cur_stage updates.
REQ-013 SHALL have port done, output, 1 bit: sticky, high in PASS or FAIL.
REQ-014 SHALL have port pass, output, 1 bit: sticky, high in PASS.
REQ-015 SHALL have port fail_code, output, 3 bits: 0 none, 1 error flag, 2 global timeout, 3 stage timeout, 4 order violation.
REQ-016 SHALL have port err_chan, output, ERR_W bits: snapshot of the synchronised err vector at the failing sample.

Function
REQ-017 SHALL pass stage and err through a two-flop synchroniser each; all decisions use the synchronised values.
REQ-018 SHALL run a prescaler counting 0..SAMPLE_DIV-1 and assert the internal strobe on terminal count, then wrap to 0.
REQ-019 SHALL implement states RUN, PASS and FAIL; leave RUN only on a strobe; PASS and FAIL are absorbing until reset.
REQ-020 SHALL evaluate in RUN at each strobe in this priority order: any err bit set -> FAIL, code 1; stage == PASS_CODE -> PASS; global count == GLOBAL_TO-1 -> FAIL, code 2; stage count == STAGE_TO-1 with STAGE_TO != 0 -> FAIL, code 3.
REQ-021 SHALL, on a strobe where stage differs from cur_stage, load cur_stage, pulse stage_evt in the next cycle and clear the stage counter, including on the strobe that enters PASS.
REQ-022 SHALL increment the global count and the stage count on every strobe in RUN that causes no state exit; counters saturate and never wrap.
REQ-023 SHALL treat an error flag and PASS_CODE on the same strobe as FAIL code 1.
REQ-024 SHALL treat a stage change and a stage timeout on the same strobe as a change, with no timeout.
REQ-025 SHALL update done, pass, fail_code and err_chan in the cycle after the deciding strobe, and hold them constant afterwards.
REQ-026 SHALL freeze cur_stage and suppress stage_evt in PASS and FAIL.

Reset
REQ-027 SHALL, while RSTB is low, asynchronously clear the synchronisers, prescaler, both counters, cur_stage, stage_evt, done, pass, fail_code and err_chan, and enter RUN.
REQ-028 SHALL, when RSTB asserts mid-run, abandon the run; after release it restarts with the first strobe SAMPLE_DIV cycles later.

Configuration
REQ-029 SHALL, with STAGE_ORDER_CHECK_EN defined, accept a stage change only to cur_stage+1 (mod 2^STAGE_W), to PASS_CODE or to all-ones; any other change -> FAIL, code 4, ranked after the error flag in priority.
REQ-030 SHALL, without STAGE_ORDER_CHECK_EN, accept any stage change and never produce code 4.

Verification
REQ-031 SHALL cover: SAMPLE_DIV=4, stage 0->1->2->254 -> three stage_evt pulses, pass=1, fail_code=0, done at the strobe after 254 plus one cycle.
REQ-032 SHALL cover: ERR_W=4, err=4'b0100 with stage=254 on the same strobe -> pass=0, fail_code=1, err_chan=4'b0100.
REQ-033 SHALL cover: GLOBAL_TO=10, stage toggling each strobe, never 254 -> fail_code=2 on the 10th strobe.
REQ-034 SHALL cover: STAGE_TO=5, stage held at 3 -> fail_code=3 on the 5th strobe after acceptance; STAGE_TO=0 -> no code 3.
REQ-035 SHALL cover: STAGE_ORDER_CHECK_EN defined, stage 1->3 -> fail_code=4; undefined -> cur_stage=3 and no failure.
REQ-036 SHALL cover: RSTB pulsed low mid-run at stage 2 -> all outputs 0, done=0, and the run resumes normally after release.
